led_share_arbiter: RTL and testbench
====================================

# led_share_arbiter

Round-robin arbiter that shares the board LED bank between several internal requesters, such as a status monitor, a debug pattern generator or a build-info blinker. Each requester presents a request bit and an LED pattern. The arbiter grants exactly one requester at a time, enforces a bounded hold time under contention, and drives the registered LED outputs toward the top-level pins. It sits directly below the top level, in the `clk_ext` domain.

## Interface
- `num_requesters`, default 4: number of requesters. Legal range 1..16.
- `num_leds`, default 4: LED bank width.
- `hold_cycles`, default 1000: maximum grant length, in cycles, while another requester is waiting. Must be at least 2.

Ports:
- `clk_ext`  in  1: the single clock; all logic is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `request`  in  num_requesters: request bit per requester; level-sensitive.
- `led_pattern`  in  num_requesters*num_leds: requester k's pattern is bits [k*num_leds +: num_leds].
- `grant`  out  num_requesters: one-hot grant, registered; all zeros when idle.
- `led`  out  num_leds: registered LED drive.
- `busy`  out  1: registered; high exactly when `grant` is non-zero.

## Operation
- **State**
  - `owner` index.
  - `granted` flag, which gives two states: IDLE and GRANT.
  - Hold counter `hold_cnt`, $clog2(hold_cycles) bits wide.
  - Round-robin pointer `last`.
- **Reset values**
  - `grant`=0, `led`=0, `busy`=0.
  - State IDLE, `hold_cnt`=0.
  - `last`=num_requesters-1, so requester 0 wins first.
- **Arbitration event:** occurs in a cycle where any of the following holds:
  - state is IDLE;
  - state is GRANT and `request[owner]`=0;
  - state is GRANT and `hold_cnt`=hold_cycles-1.
- **Winner selection**
  - The winner is the first set `request` bit searched in order last+1, last+2, …, last, with wrap-around.
  - The current owner is therefore searched last and is re-granted only if no other requester is waiting.
- **Result of an arbitration event**
  - Winner found: on the next edge, GRANT state, `owner`=`last`=winner, `hold_cnt`=0, `grant`=one-hot(winner).
  - No winner: on the next edge, IDLE state and `grant`=0.
- **In GRANT with no arbitration event:** `hold_cnt` increments by 1 per cycle.
- **Hold counter wrap:** `hold_cnt` never wraps past hold_cycles-1, because reaching that value always triggers arbitration.
- **LED drive**
  - In a cycle where the next state is GRANT: `led` <= pattern of the next owner.
  - Otherwise: `led` <= idle value (see Configuration).
- **Single requester (num_requesters=1):** the grant is re-issued at every expiry with no gap.
- **Simultaneous requests:** ties are resolved purely by pointer order.
- **Request changes outside arbitration events:** ignored.

## Timing
- **Request to grant:** 1 cycle from IDLE. A request sampled at edge N gives `grant`/`busy`/`led` valid after edge N+1.
- **Pattern to LED:** 1 cycle latency while granted. `led` tracks the owner's pattern every cycle.
- **Hold limit:** under continuous contention, each grant lasts exactly hold_cycles cycles.
- **Handover:** back-to-back, with no idle cycle between owners.
- **Release:** if the owner deasserts `request` at edge N, `grant` changes after edge N+1. The owner therefore sees one extra grant cycle.
- **Reset mid-operation:** all outputs go to their reset values asynchronously. After reset is released, the first grant goes to the lowest-indexed requester.

## Configuration
- **Macro:** `LED_SHARE_ARBITER_HEARTBEAT_EN`.
- **Defined**
  - Idle value: `led[0]` toggles every hold_cycles cycles, and the other LEDs are 0.
  - The toggle counter runs only in IDLE and restarts from 0 at each entry to IDLE, with `led[0]`=0.
  - The first toggle occurs hold_cycles cycles after entering IDLE.
- **Undefined:** the idle value is all zeros, and no heartbeat counter logic is present.

## Test plan
- **Reset:** assert `reset` mid-simulation with no clock edge -> `grant`=0, `led`=0, `busy`=0 immediately.
- **Single requester grant and release:** with hold_cycles=4, `request`=4'b0100 and pattern2=4'b1010 at edge 0 -> `grant`=4'b0100, `busy`=1, `led`=4'b1010 after edge 1. Drop `request` at edge 5 -> `grant`=0, `led`=0 after edge 6.
- **Contention:** with hold_cycles=4, `request`=4'b0011 held -> `grant` sequence is 0001 ×4 cycles, 0010 ×4, 0001 ×4, with no gaps.
- **Early release:** requester 0 owns the grant and requester 3 is waiting. Requester 0 drops at its 2nd grant cycle -> `grant`=4'b1000 on the following cycle with `hold_cnt` restarted, and requester 3 holds for 4 cycles.
- **Reset mid-grant:** `reset` pulsed while `grant`=4'b0100 and `request`=4'b0101 remains asserted -> `grant`=0 during reset; the first grant after release is 4'b0001.
- **Heartbeat:** with the macro defined, hold_cycles=4 and idle -> `led`=0001 and 0000 alternating every 4 cycles. With the macro undefined -> `led`=0000 constant.

Source files
------------

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the LED bank with bounded hold under contention; all outputs registered.
// Optional idle heartbeat on led[0]: LED_SHARE_ARBITER_HEARTBEAT_EN.
module led_share_arbiter #(
  parameter int num_requesters = 4,
  parameter int num_leds       = 4,
  parameter int hold_cycles    = 1000
) (
  input  logic                                clk_ext,
  input  logic                                reset,
  input  logic [num_requesters-1:0]           request,
  input  logic [num_requesters*num_leds-1:0]  led_pattern,
  output logic [num_requesters-1:0]           grant,
  output logic [num_leds-1:0]                 led,
  output logic                                busy
);
  localparam int OW = (num_requesters > 1) ? $clog2(num_requesters) : 1;
  localparam int HW = $clog2(hold_cycles);
  localparam logic [HW-1:0] HOLD_MAX = HW'(hold_cycles - 1);
  localparam logic [OW-1:0] LAST_RST = OW'(num_requesters - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                    r_state, w_state_nxt;
  logic [OW-1:0]             r_owner, r_last, w_owner_nxt, w_win;
  logic [HW-1:0]             r_hold_cnt, w_hold_nxt;
  logic                      w_found, w_arb;
  logic [num_requesters-1:0] w_grant_nxt;
  logic [num_leds-1:0]       w_led_nxt, w_idle_led;

  // Search last+1 .. last, so the current owner is considered only after everyone else.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 1; i <= num_requesters; i++) begin
      if (!w_found && request[(int'(r_last) + i) % num_requesters]) begin
        w_found = 1'b1;
        w_win   = OW'((int'(r_last) + i) % num_requesters);
      end
    end
  end

  assign w_arb = (r_state == IDLE) || !request[r_owner] || (r_hold_cnt == HOLD_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold_cnt;
    if (w_arb) begin
      w_hold_nxt = '0;
      if (w_found) begin
        w_state_nxt = GRANT;
        w_owner_nxt = w_win;
      end else begin
        w_state_nxt = IDLE;
      end
    end else begin
      w_hold_nxt = r_hold_cnt + HW'(1);
    end
  end

`ifdef LED_SHARE_ARBITER_HEARTBEAT_EN
  logic [HW-1:0] r_hb_cnt, w_hb_cnt_nxt;
  logic          r_hb_led, w_hb_led_nxt;

  // Runs only while staying idle; any other transition restarts it dark.
  always_comb begin
    w_hb_cnt_nxt = '0;
    w_hb_led_nxt = 1'b0;
    if (r_state == IDLE && w_state_nxt == IDLE) begin
      if (r_hb_cnt == HOLD_MAX) begin
        w_hb_led_nxt = ~r_hb_led;
      end else begin
        w_hb_cnt_nxt = r_hb_cnt + HW'(1);
        w_hb_led_nxt = r_hb_led;
      end
    end
  end

  always_ff @(posedge clk_ext or posedge reset) begin
    if (reset) begin
      r_hb_cnt <= '0;
      r_hb_led <= 1'b0;
    end else begin
      r_hb_cnt <= w_hb_cnt_nxt;
      r_hb_led <= w_hb_led_nxt;
    end
  end

  always_comb begin
    w_idle_led    = '0;
    w_idle_led[0] = w_hb_led_nxt;
  end
`else
  assign w_idle_led = '0;
`endif

  always_comb begin
    w_grant_nxt = '0;
    w_led_nxt   = w_idle_led;
    if (w_state_nxt == GRANT) begin
      w_grant_nxt[w_owner_nxt] = 1'b1;
      w_led_nxt = led_pattern[int'(w_owner_nxt)*num_leds +: num_leds];
    end
  end

  always_ff @(posedge clk_ext or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= LAST_RST;
      r_hold_cnt <= '0;
      grant      <= '0;
      led        <= '0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
      if (w_arb && w_found) r_last <= w_win;
      grant      <= w_grant_nxt;
      led        <= w_led_nxt;
      busy       <= (w_state_nxt == GRANT);
    end
  end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed stimulus pushes expected outputs keyed by cycle; a negedge monitor pops and compares.
module tb_led_share_arbiter;
  logic        clk_ext = 1'b0;
  logic        reset;
  logic [3:0]  request;
  logic [15:0] led_pattern;
  logic [3:0]  grant;
  logic [3:0]  led;
  logic        busy;

`ifdef LED_SHARE_ARBITER_HEARTBEAT_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif

  led_share_arbiter #(.num_requesters(4), .num_leds(4), .hold_cycles(4)) dut (
    .clk_ext(clk_ext), .reset(reset), .request(request), .led_pattern(led_pattern),
    .grant(grant), .led(led), .busy(busy)
  );

  always #5 clk_ext = ~clk_ext;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [3:0] l;
    logic       b;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clk_ext) cyc <= cyc + 1;

  always @(negedge clk_ext) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || grant !== e.g || led !== e.l || busy !== e.b) begin
        n_fail++;
        $display("FAIL %s cyc=%0d (due %0d) grant=%b want %b led=%b want %b busy=%b want %b",
                 e.nm, cyc, e.cyc, grant, e.g, led, e.l, busy, e.b);
      end
    end
  end

  task automatic tick();
    @(posedge clk_ext);
    #1;
  endtask

  task automatic push(input int dc, input logic [3:0] g, input logic [3:0] l,
                      input logic b, input string nm);
    exp_t x;
    x.cyc = cyc + dc; x.g = g; x.l = l; x.b = b; x.nm = nm;
    q.push_back(x);
  endtask

  // Drive one cycle of request and expect the registered outputs after the next edge.
  task automatic step(input logic [3:0] req, input logic [3:0] g, input logic [3:0] l,
                      input logic b, input string nm);
    request = req;
    push(1, g, l, b, nm);
    tick();
  endtask

  task automatic step_nochk(input logic [3:0] req);
    request = req;
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    request     = 4'b0000;
    led_pattern = 16'hCA31;  // p3=1100 p2=1010 p1=0011 p0=0001
    tick();
    push(0, 4'b0000, 4'b0000, 1'b0, "reset_init");
    tick();
    tick();
    reset = 1'b0;
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, "idle_a");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, "idle_b");

    // single requester: grant, pattern tracking, re-grant at expiry with no gap, release
    step(4'b0100, 4'b0100, 4'b1010, 1'b1, "single_grant");
    step(4'b0100, 4'b0100, 4'b1010, 1'b1, "single_hold1");
    step(4'b0100, 4'b0100, 4'b1010, 1'b1, "single_hold2");
    led_pattern = 16'hC631;
    step(4'b0100, 4'b0100, 4'b0110, 1'b1, "pattern_track");
    step(4'b0100, 4'b0100, 4'b0110, 1'b1, "regrant_nogap");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, "release");
    led_pattern = 16'hCA31;

    // contention between 0 and 1: 4 cycles each, no gaps
    for (int k = 0; k < 12; k++) begin
      if ((k / 4) % 2 == 0) step(4'b0011, 4'b0001, 4'b0001, 1'b1, "contend_r0");
      else                  step(4'b0011, 4'b0010, 4'b0011, 1'b1, "contend_r1");
    end
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, "contend_idle");

    // early release by 0 hands to waiting 3, whose hold count restarts
    step(4'b0001, 4'b0001, 4'b0001, 1'b1, "er_grant");
    step(4'b1001, 4'b0001, 4'b0001, 1'b1, "er_hold");
    step(4'b1000, 4'b1000, 4'b1100, 1'b1, "er_handover");
    step(4'b1010, 4'b1000, 4'b1100, 1'b1, "er_r3_c2");
    step(4'b1010, 4'b1000, 4'b1100, 1'b1, "er_r3_c3");
    step(4'b1010, 4'b1000, 4'b1100, 1'b1, "er_r3_c4");
    step(4'b1010, 4'b0010, 4'b0011, 1'b1, "er_expire");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, "er_idle");

    // reset pulsed mid-grant with requests still asserted
    step(4'b0100, 4'b0100, 4'b1010, 1'b1, "rg_grant");
    step_nochk(4'b0101);
    reset = 1'b1;
    push(0, 4'b0000, 4'b0000, 1'b0, "rg_async");
    step(4'b0101, 4'b0000, 4'b0000, 1'b0, "rg_in_reset");
    reset = 1'b0;
    step(4'b0101, 4'b0001, 4'b0001, 1'b1, "rg_first");

    // idle LED value
    for (int j = 0; j < 12; j++) begin
      step(4'b0000, 4'b0000, {3'b000, HB & (((j / 4) % 2) == 1)}, 1'b0, "idle_led");
    end

    tick();
    tick();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
